// File: rtl/reg_scan_reader.sv
// reg_scan_reader: walks a register file read port from FIRST_REG to LAST_REG.
// Each register value is offered to a valid/ready sink. A rotate-add checksum
// is kept over every word the sink accepts.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for i_start; checksum and last outputs held
//   S_FETCH | o_rf_a = idx; RF data captured into the output holding regs
//   S_HOLD  | word offered on o_out_*; wait for the sink's handshake
module reg_scan_reader #(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 15
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_abort,
   output logic [3:0]  o_rf_a,
   input  logic [31:0] i_rf_rd,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [31:0] o_out_data,
   output logic [3:0]  o_out_idx,
   output logic        o_out_last,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_checksum
);

   localparam logic [3:0] C_FIRST = 4'(FIRST_REG);
   localparam logic [3:0] C_LAST  = 4'(LAST_REG);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_idx;
   logic        r_out_valid;
   logic [31:0] r_out_data;
   logic [3:0]  r_out_idx;
   logic        r_out_last;
   logic        r_done;
   logic [31:0] r_checksum;
   logic        w_hs;

   assign w_hs = (r_state == S_HOLD) & r_out_valid & i_out_ready;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state logic; abort wins over the handshake outcome
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_FETCH;
         S_FETCH: w_next = i_abort ? S_IDLE : S_HOLD;
         S_HOLD: begin
            if (i_abort)        w_next = S_IDLE;
            else if (w_hs)      w_next = r_out_last ? S_IDLE : S_FETCH;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Index, output holding registers, checksum and done pulse
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_idx       <= 4'd0;
         r_out_valid <= 1'b0;
         r_out_data  <= 32'd0;
         r_out_idx   <= 4'd0;
         r_out_last  <= 1'b0;
         r_done      <= 1'b0;
         r_checksum  <= 32'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_idx      <= C_FIRST;
                  r_checksum <= 32'd0;
               end
            end
            S_FETCH: begin
               r_out_data  <= i_rf_rd;
               r_out_idx   <= r_idx;
               r_out_last  <= (r_idx == C_LAST);
               r_out_valid <= ~i_abort;
            end
            S_HOLD: begin
               if (w_hs) begin
                  r_checksum  <= {r_checksum[30:0], r_checksum[31]} + r_out_data;
                  r_out_valid <= 1'b0;
                  if (r_out_last)    r_done <= ~i_abort;
                  else if (!i_abort) r_idx  <= r_idx + 4'd1;
               end
               if (i_abort) r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign o_rf_a      = r_idx;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_idx   = r_out_idx;
   assign o_out_last  = r_out_last;
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = r_done;
   assign o_checksum  = r_checksum;

endmodule
